ycr_tcm_banked: RTL and testbench
=================================

YCR_TCM_BANKED -- requirements
Module: ycr_tcm_banked

Interface
REQ-001 SHALL have parameter NBANK, default 2: SRAM bank count; power of two, 2..8.
REQ-002 SHALL have parameter BANK_AW, default 9: word-address width per bank.
REQ-003 SHALL have parameter TCM_AW, default 32: core address width.
REQ-004 SHALL have port clk, in, 1: single clock for all logic; SRAM clocks driven from it.
REQ-005 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-006 SHALL have imem port group, per signal (name, direction, width, meaning):
- imem_req, in, 1: instruction fetch request.
- imem_addr, in, TCM_AW: fetch byte address.
- imem_req_ack, out, 1: request accepted this cycle.
- imem_rdata, out, 32: fetch data.
- imem_resp, out, 2: 0 NOTRDY, 1 RDY_OK, 2 RDY_ER.
REQ-007 SHALL have dmem port group, per signal (name, direction, width, meaning):
- dmem_req, in, 1: data request.
- dmem_cmd, in, 1: 0 read, 1 write.
- dmem_width, in, 2: 0 byte, 1 halfword, 2 word.
- dmem_addr, in, TCM_AW: byte address.
- dmem_wdata, in, 32: write data, LSB-aligned.
- dmem_req_ack, out, 1: request accepted this cycle.
- dmem_rdata, out, 32: read data, LSB-aligned.
- dmem_resp, out, 2: encoding as imem_resp.
REQ-008 SHALL have SRAM port group, flattened, one slice per bank b (name, direction, width, meaning):
- sram_clk0, out, NBANK: port-0 clocks.
- sram_csb0, out, NBANK: port-0 chip select, active-low.
- sram_web0, out, NBANK: port-0 write enable, active-low.
- sram_addr0, out, NBANK*BANK_AW: port-0 word address.
- sram_wmask0, out, NBANK*4: port-0 byte write mask.
- sram_din0, out, NBANK*32: port-0 write data.
- sram_dout0, in, NBANK*32: port-0 read data.
- sram_clk1, out, NBANK: port-1 clocks.
- sram_csb1, out, NBANK: port-1 chip select, active-low.
- sram_addr1, out, NBANK*BANK_AW: port-1 word address.
- sram_dout1, in, NBANK*32: port-1 read data.

Function
REQ-009 SHALL decode addresses as follows: word = addr[2+:BANK_AW]; bank = addr[2+BANK_AW +: log2(NBANK)]; in-range iff addr < NBANK*4*2^BANK_AW.
REQ-010 SHALL route imem to SRAM port 1 and dmem to SRAM port 0.
REQ-011 SHALL drive imem_req_ack and dmem_req_ack combinationally, with no pending state required.
REQ-012 SHALL assert dmem_req_ack = dmem_req at all times.
REQ-013 SHALL assert imem_req_ack = imem_req & !conflict.
REQ-014 SHALL define conflict as a same-cycle dmem write to the same in-range bank and word as the imem address; on conflict imem waits and SHALL be retried next cycle with no SRAM access.
REQ-015 SHALL accept a new request on each port every cycle and pipeline it to a fixed 2-cycle response: accept in cycle A, SRAM select in A, dout captured in A+1, resp/rdata registered and valid in A+2 for exactly one cycle.
REQ-016 SHALL assert csb0/csb1 low only for the addressed bank of an accepted, in-range, aligned request; all other banks stay deselected.
REQ-017 SHALL treat any of the following as an error request: out-of-range address, halfword with addr[0]=1, word with addr[1:0]!=0, or dmem_width=3.
REQ-018 SHALL not access SRAM for an error request and SHALL return RDY_ER at A+2 with rdata 0.
REQ-019 SHALL apply write masks as follows: byte -> 4'b0001<<addr[1:0], data replicated x4; halfword -> 4'b0011<<{addr[1],0}, data replicated x2; word -> 4'b1111.
REQ-020 SHALL return RDY_OK at A+2 for writes, with dmem_rdata 0.
REQ-021 SHALL, for reads, pipeline the bank index and addr[1:0] with the request and form dmem_rdata = selected dout0 >> (8*addr[1:0]) with upper bits zero, leaving sign extension to the core.
REQ-022 SHALL form imem_rdata = selected bank dout1, unshifted.
REQ-023 SHALL drive resp = 0 (NOTRDY) in every cycle not carrying a response.
REQ-024 SHALL keep dmem and imem pipelines independent: back-to-back dmem write then read to the same word returns the newly written data.

Reset
REQ-025 SHALL, while rst=1, force all pipeline stages to invalid, both resp outputs to 0, both rdata outputs to 0, and every csb0/csb1/web0 bit to 1.
REQ-026 SHALL discard requests in flight when rst asserts mid-operation, producing no response after release.
REQ-027 SHALL permit acceptance from the first clk edge after rst deasserts.

Verification
REQ-028 SHALL cover continuous imem fetches 0x0, 0x4, 0x8 -> imem_req_ack=1 each cycle; RDY_OK with matching data at cycles A+2, A+3, A+4.
REQ-029 SHALL cover NBANK=4 dmem byte write 0xA5 to 0x803 -> bank 1 csb0=0, wmask0=4'b1000, din0=0xA5A5A5A5; read-back yields rdata 0x000000A5.
REQ-030 SHALL cover same-cycle imem read and dmem write to 0x10 -> imem_req_ack=0 that cycle, 1 next cycle; fetch returns new data.
REQ-031 SHALL cover dmem word read at 0x2002 and imem fetch at 0x4000 (NBANK=2) -> both RDY_ER at A+2, no csb asserted.
REQ-032 SHALL cover rst pulse one cycle after an accepted read -> resp stays 0 on all subsequent cycles until a new request.

Source files
------------

// File: rtl/ycr_tcm_banked.sv
// Banked tightly-coupled memory: dmem on SRAM port 0 (read/write), imem on port 1 (read-only).
// Both ports accept one request per cycle and answer exactly two cycles later.
module ycr_tcm_banked #(
  parameter int NBANK   = 2,
  parameter int BANK_AW = 9,
  parameter int TCM_AW  = 32
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       imem_req,
  input  logic [TCM_AW-1:0]          imem_addr,
  output logic                       imem_req_ack,
  output logic [31:0]                imem_rdata,
  output logic [1:0]                 imem_resp,

  input  logic                       dmem_req,
  input  logic                       dmem_cmd,
  input  logic [1:0]                 dmem_width,
  input  logic [TCM_AW-1:0]          dmem_addr,
  input  logic [31:0]                dmem_wdata,
  output logic                       dmem_req_ack,
  output logic [31:0]                dmem_rdata,
  output logic [1:0]                 dmem_resp,

  output logic [NBANK-1:0]           sram_clk0,
  output logic [NBANK-1:0]           sram_csb0,
  output logic [NBANK-1:0]           sram_web0,
  output logic [NBANK*BANK_AW-1:0]   sram_addr0,
  output logic [NBANK*4-1:0]         sram_wmask0,
  output logic [NBANK*32-1:0]        sram_din0,
  input  logic [NBANK*32-1:0]        sram_dout0,
  output logic [NBANK-1:0]           sram_clk1,
  output logic [NBANK-1:0]           sram_csb1,
  output logic [NBANK*BANK_AW-1:0]   sram_addr1,
  input  logic [NBANK*32-1:0]        sram_dout1
);

  localparam int BW        = $clog2(NBANK);
  localparam int RANGE_LSB = 2 + BANK_AW + BW;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;

  // Request decode (cycle A)
  logic [BANK_AW-1:0] d_word;
  logic [BANK_AW-1:0] i_word;
  logic [BW-1:0]      d_bank;
  logic [BW-1:0]      i_bank;
  logic               d_in_range;
  logic               i_in_range;
  logic               d_misalign;
  logic               d_err;
  logic               i_err;
  logic               conflict;
  logic               d_access;
  logic               i_access;
  logic [3:0]         d_mask;
  logic [31:0]        d_din;

  assign d_word     = dmem_addr[2 +: BANK_AW];
  assign i_word     = imem_addr[2 +: BANK_AW];
  assign d_bank     = dmem_addr[2+BANK_AW +: BW];
  assign i_bank     = imem_addr[2+BANK_AW +: BW];
  assign d_in_range = ((dmem_addr >> RANGE_LSB) == '0);
  assign i_in_range = ((imem_addr >> RANGE_LSB) == '0);

  always_comb begin
    d_misalign = 1'b0;
    d_mask     = 4'b1111;
    d_din      = dmem_wdata;
    case (dmem_width)
      2'd0: begin
        d_mask = 4'b0001 << dmem_addr[1:0];
        d_din  = {4{dmem_wdata[7:0]}};
      end
      2'd1: begin
        d_misalign = dmem_addr[0];
        d_mask     = 4'b0011 << {dmem_addr[1], 1'b0};
        d_din      = {2{dmem_wdata[15:0]}};
      end
      2'd2: begin
        d_misalign = |dmem_addr[1:0];
      end
      default: begin
        d_misalign = 1'b1;
      end
    endcase
  end

  // Fetches are whole words, so a fetch address must be word aligned.
  assign d_err = ~d_in_range | d_misalign;
  assign i_err = ~i_in_range | (|imem_addr[1:0]);

  // A fetch of the word being written this cycle is held off one cycle so it sees the new data.
  assign conflict = dmem_req & dmem_cmd & d_in_range & i_in_range &
                    (d_bank == i_bank) & (d_word == i_word);

  assign dmem_req_ack = dmem_req;
  assign imem_req_ack = imem_req & ~conflict;

  assign d_access = dmem_req & ~d_err;
  assign i_access = imem_req_ack & ~i_err;

  // Per-bank SRAM drive and read-data unpacking
  logic [31:0] dout0_arr [NBANK];
  logic [31:0] dout1_arr [NBANK];

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      localparam logic [BW-1:0] BANK_ID = BW'(gi);
      logic d_sel;
      logic i_sel;

      assign d_sel = d_access & (d_bank == BANK_ID);
      assign i_sel = i_access & (i_bank == BANK_ID);

      assign sram_clk0[gi]                     = clk;
      assign sram_csb0[gi]                     = rst | ~d_sel;
      assign sram_web0[gi]                     = rst | ~(d_sel & dmem_cmd);
      assign sram_addr0[gi*BANK_AW +: BANK_AW] = d_word;
      assign sram_wmask0[gi*4 +: 4]            = d_mask;
      assign sram_din0[gi*32 +: 32]            = d_din;

      assign sram_clk1[gi]                     = clk;
      assign sram_csb1[gi]                     = rst | ~i_sel;
      assign sram_addr1[gi*BANK_AW +: BANK_AW] = i_word;

      assign dout0_arr[gi] = sram_dout0[gi*32 +: 32];
      assign dout1_arr[gi] = sram_dout1[gi*32 +: 32];
    end
  endgenerate

  // Stage 1: request attributes travel alongside the SRAM access (captured end of A)
  logic          d_vld_q,  d_vld_d;
  logic          d_err_q,  d_err_d;
  logic          d_rd_q,   d_rd_d;
  logic [BW-1:0] d_bank_q, d_bank_d;
  logic [1:0]    d_off_q,  d_off_d;
  logic          i_vld_q,  i_vld_d;
  logic          i_err_q,  i_err_d;
  logic [BW-1:0] i_bank_q, i_bank_d;

  // Stage 2: registered responses (valid during A+2)
  logic [1:0]  dmem_resp_q,  dmem_resp_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic [1:0]  imem_resp_q,  imem_resp_d;
  logic [31:0] imem_rdata_q, imem_rdata_d;

  always_comb begin
    d_vld_d  = dmem_req;
    d_err_d  = d_err;
    d_rd_d   = ~dmem_cmd;
    d_bank_d = d_bank;
    d_off_d  = dmem_addr[1:0];
    i_vld_d  = imem_req_ack;
    i_err_d  = i_err;
    i_bank_d = i_bank;
  end

  always_comb begin
    dmem_resp_d  = RESP_NOTRDY;
    dmem_rdata_d = '0;
    if (d_vld_q) begin
      if (d_err_q) begin
        dmem_resp_d = RESP_ER;
      end else begin
        dmem_resp_d = RESP_OK;
        if (d_rd_q) begin
          dmem_rdata_d = dout0_arr[d_bank_q] >> {d_off_q, 3'b000};
        end
      end
    end

    imem_resp_d  = RESP_NOTRDY;
    imem_rdata_d = '0;
    if (i_vld_q) begin
      if (i_err_q) begin
        imem_resp_d = RESP_ER;
      end else begin
        imem_resp_d  = RESP_OK;
        imem_rdata_d = dout1_arr[i_bank_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_vld_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rd_q       <= 1'b0;
      d_bank_q     <= '0;
      d_off_q      <= '0;
      i_vld_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_bank_q     <= '0;
      dmem_resp_q  <= RESP_NOTRDY;
      dmem_rdata_q <= '0;
      imem_resp_q  <= RESP_NOTRDY;
      imem_rdata_q <= '0;
    end else begin
      d_vld_q      <= d_vld_d;
      d_err_q      <= d_err_d;
      d_rd_q       <= d_rd_d;
      d_bank_q     <= d_bank_d;
      d_off_q      <= d_off_d;
      i_vld_q      <= i_vld_d;
      i_err_q      <= i_err_d;
      i_bank_q     <= i_bank_d;
      dmem_resp_q  <= dmem_resp_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_resp_q  <= imem_resp_d;
      imem_rdata_q <= imem_rdata_d;
    end
  end

  assign dmem_resp  = dmem_resp_q;
  assign dmem_rdata = dmem_rdata_q;
  assign imem_resp  = imem_resp_q;
  assign imem_rdata = imem_rdata_q;

endmodule

// File: tb/tb_ycr_tcm_banked.sv
// Bench for ycr_tcm_banked (NBANK=4): SRAM bank models, byte-level reference memory,
// table-driven directed vectors, randomized traffic and hand-written corner sequences.
module tb_ycr_tcm_banked;
  localparam int NBANK   = 4;
  localparam int BANK_AW = 9;
  localparam int TCM_AW  = 32;
  localparam int BANK_BYTES = 4 * (1 << BANK_AW);
  localparam int LIMIT      = NBANK * BANK_BYTES;

  localparam logic [1:0] NOTRDY = 2'd0;
  localparam logic [1:0] OK     = 2'd1;
  localparam logic [1:0] ER     = 2'd2;

  logic clk, rst;
  logic imem_req, imem_req_ack;
  logic [TCM_AW-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0] imem_resp;
  logic dmem_req, dmem_cmd, dmem_req_ack;
  logic [1:0] dmem_width, dmem_resp;
  logic [TCM_AW-1:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [NBANK-1:0] sram_clk0, sram_csb0, sram_web0, sram_clk1, sram_csb1;
  logic [NBANK*BANK_AW-1:0] sram_addr0, sram_addr1;
  logic [NBANK*4-1:0] sram_wmask0;
  logic [NBANK*32-1:0] sram_din0, sram_dout0, sram_dout1;

  ycr_tcm_banked #(.NBANK(NBANK), .BANK_AW(BANK_AW), .TCM_AW(TCM_AW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_wmask0(sram_wmask0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .sram_clk1(sram_clk1), .sram_csb1(sram_csb1),
    .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM bank models: synchronous read, masked write on port 0
  bit   [31:0] sram_mem [NBANK][1 << BANK_AW];
  logic [31:0] dout0_m [NBANK];
  logic [31:0] dout1_m [NBANK];

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[k]) o[k*8 +: 8] = d[k*8 +: 8];
    return o;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (!sram_csb0[b]) begin
        if (!sram_web0[b])
          sram_mem[b][sram_addr0[b*BANK_AW +: BANK_AW]] <=
            merge(sram_mem[b][sram_addr0[b*BANK_AW +: BANK_AW]], sram_din0[b*32 +: 32], sram_wmask0[b*4 +: 4]);
        else
          dout0_m[b] <= sram_mem[b][sram_addr0[b*BANK_AW +: BANK_AW]];
      end
      if (!sram_csb1[b]) dout1_m[b] <= sram_mem[b][sram_addr1[b*BANK_AW +: BANK_AW]];
    end
  end

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_dout
      assign sram_dout0[gi*32 +: 32] = dout0_m[gi];
      assign sram_dout1[gi*32 +: 32] = dout1_m[gi];
    end
  endgenerate

  // Reference model: flat byte memory plus queues of responses due at a given cycle
  bit [7:0] ref_mem [LIMIT];
  typedef struct { int due; logic [1:0] resp; logic [31:0] rdata; } exp_t;
  exp_t iq[$];
  exp_t dq[$];
  int cyc;
  int n_vec, n_mis;

  function automatic logic [31:0] word_at(int a);
    int w = a - (a % 4);
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (iq.size() > 0 && iq[0].due == cyc) begin
      e = iq.pop_front();
      chk("imem_resp", imem_resp, e.resp);
      chk("imem_rdata", imem_rdata, e.rdata);
    end else chk("imem_resp_idle", imem_resp, NOTRDY);
    if (dq.size() > 0 && dq[0].due == cyc) begin
      e = dq.pop_front();
      chk("dmem_resp", dmem_resp, e.resp);
      chk("dmem_rdata", dmem_rdata, e.rdata);
    end else chk("dmem_resp_idle", dmem_resp, NOTRDY);
  endtask

  // One clock cycle: drive at negedge, check acks/selects, update the model, check responses after posedge
  task automatic tick(input bit ir, input logic [31:0] ia, input bit dr, input bit dc,
                      input logic [1:0] dw, input logic [31:0] da, input logic [31:0] dwd);
    int a, i;
    bit d_inr, i_inr, d_bad, i_bad, confl, iack;
    logic [3:0] e_csb0, e_csb1;
    exp_t e;
    @(negedge clk);
    imem_req = ir; imem_addr = ia;
    dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
    #1;
    a = int'(da); i = int'(ia);
    d_inr = (da < LIMIT);
    i_inr = (ia < LIMIT);
    d_bad = !d_inr || dw == 2'd3 || (dw == 2'd1 && a % 2 != 0) || (dw == 2'd2 && a % 4 != 0);
    i_bad = !i_inr || i % 4 != 0;
    confl = dr && dc && d_inr && i_inr && (a / 4 == i / 4);
    iack  = ir && !confl;
    chk("dmem_req_ack", dmem_req_ack, dr);
    chk("imem_req_ack", imem_req_ack, iack);
    e_csb0 = 4'hF; e_csb1 = 4'hF;
    if (dr && !d_bad) begin
      e_csb0[a / BANK_BYTES] = 1'b0;
      chk("web0", sram_web0[a / BANK_BYTES], !dc);
    end
    if (iack && !i_bad) e_csb1[i / BANK_BYTES] = 1'b0;
    chk("csb0", sram_csb0, e_csb0);
    chk("csb1", sram_csb1, e_csb1);
    if (iack) begin
      e.due = cyc + 2; e.resp = i_bad ? ER : OK; e.rdata = i_bad ? 32'h0 : word_at(i);
      iq.push_back(e);
    end
    if (dr) begin
      e.due = cyc + 2; e.resp = d_bad ? ER : OK; e.rdata = 32'h0;
      if (!d_bad && !dc) e.rdata = word_at(a) >> (8 * (a % 4));
      dq.push_back(e);
      if (!d_bad && dc) begin
        ref_mem[a] = dwd[7:0];
        if (dw >= 2'd1) ref_mem[a+1] = dwd[15:8];
        if (dw == 2'd2) begin ref_mem[a+2] = dwd[23:16]; ref_mem[a+3] = dwd[31:24]; end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_resp();
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom % 16 == 0) return LIMIT + ($urandom % LIMIT);
    return ($urandom % NBANK) * BANK_BYTES + ($urandom % 8) * 4 + ($urandom % 4);
  endfunction

  typedef struct {
    bit ir; logic [31:0] ia;
    bit dr; bit dc; logic [1:0] dw; logic [31:0] da; logic [31:0] dwd;
    bit e_iack; logic [1:0] e_iresp; logic [31:0] e_irdata;
    logic [1:0] e_dresp; logic [31:0] e_drdata;
    int e_dbank; int e_ibank; logic [3:0] e_wmask; logic [31:0] e_din;
  } vec_t;

  function automatic vec_t mkv(bit ir, logic [31:0] ia, bit dr, bit dc, logic [1:0] dw,
                               logic [31:0] da, logic [31:0] dwd, bit e_iack,
                               logic [1:0] e_iresp, logic [31:0] e_irdata,
                               logic [1:0] e_dresp, logic [31:0] e_drdata,
                               int e_dbank, int e_ibank, logic [3:0] e_wmask, logic [31:0] e_din);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dc = dc; v.dw = dw; v.da = da; v.dwd = dwd;
    v.e_iack = e_iack; v.e_iresp = e_iresp; v.e_irdata = e_irdata;
    v.e_dresp = e_dresp; v.e_drdata = e_drdata;
    v.e_dbank = e_dbank; v.e_ibank = e_ibank; v.e_wmask = e_wmask; v.e_din = e_din;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    logic [3:0] exp_sel;
    n_vec = 0; n_mis = 0; cyc = 0;
    //                ir ia         dr dc dw    da          dwd          iack iresp irdata        dresp drdata        dbk ibk wmask   din
    tbl[0]  = mkv(0, 32'h0,    1, 1, 2'd2, 32'h100,  32'hDEADBEEF, 0, NOTRDY, 32'h0,        OK, 32'h0,        0, -1, 4'b1111, 32'hDEADBEEF);
    tbl[1]  = mkv(0, 32'h0,    1, 0, 2'd2, 32'h100,  32'h0,        0, NOTRDY, 32'h0,        OK, 32'hDEADBEEF, 0, -1, 4'b0000, 32'h0);
    tbl[2]  = mkv(0, 32'h0,    1, 0, 2'd0, 32'h101,  32'h0,        0, NOTRDY, 32'h0,        OK, 32'h00DEADBE, 0, -1, 4'b0000, 32'h0);
    tbl[3]  = mkv(0, 32'h0,    1, 1, 2'd1, 32'h102,  32'hFFFF1234, 0, NOTRDY, 32'h0,        OK, 32'h0,        0, -1, 4'b1100, 32'h12341234);
    tbl[4]  = mkv(0, 32'h0,    1, 0, 2'd2, 32'h100,  32'h0,        0, NOTRDY, 32'h0,        OK, 32'h1234BEEF, 0, -1, 4'b0000, 32'h0);
    tbl[5]  = mkv(1, 32'h100,  1, 0, 2'd1, 32'h102,  32'h0,        1, OK,     32'h1234BEEF, OK, 32'h00001234, 0,  0, 4'b0000, 32'h0);
    tbl[6]  = mkv(0, 32'h0,    1, 0, 2'd1, 32'h101,  32'h0,        0, NOTRDY, 32'h0,        ER, 32'h0,       -1, -1, 4'b0000, 32'h0);
    tbl[7]  = mkv(0, 32'h0,    1, 0, 2'd3, 32'h100,  32'h0,        0, NOTRDY, 32'h0,        ER, 32'h0,       -1, -1, 4'b0000, 32'h0);
    tbl[8]  = mkv(1, 32'h4000, 1, 0, 2'd2, 32'h2002, 32'h0,        1, ER,     32'h0,        ER, 32'h0,       -1, -1, 4'b0000, 32'h0);
    tbl[9]  = mkv(0, 32'h0,    1, 1, 2'd0, 32'h803,  32'h000000A5, 0, NOTRDY, 32'h0,        OK, 32'h0,        1, -1, 4'b1000, 32'hA5A5A5A5);
    tbl[10] = mkv(0, 32'h0,    1, 0, 2'd0, 32'h803,  32'h0,        0, NOTRDY, 32'h0,        OK, 32'h000000A5, 1, -1, 4'b0000, 32'h0);
    tbl[11] = mkv(1, 32'h1FFC, 0, 0, 2'd0, 32'h0,    32'h0,        1, OK,     32'h0,        NOTRDY, 32'h0,   -1,  3, 4'b0000, 32'h0);
    tbl[12] = mkv(0, 32'h0,    1, 1, 2'd2, 32'h2000, 32'h11223344, 0, NOTRDY, 32'h0,        ER, 32'h0,       -1, -1, 4'b0000, 32'h0);

    // Reset held with requests pending: nothing selected, no responses
    rst = 1'b1;
    imem_req = 1'b1; imem_addr = 32'h0;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h0; dmem_wdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csb0", sram_csb0, 4'hF);
    chk("rst_csb1", sram_csb1, 4'hF);
    chk("rst_web0", sram_web0, 4'hF);
    chk("rst_imem_resp", imem_resp, NOTRDY);
    chk("rst_dmem_resp", dmem_resp, NOTRDY);
    chk("rst_imem_rdata", imem_rdata, 32'h0);
    chk("rst_dmem_rdata", dmem_rdata, 32'h0);
    #1;
    rst = 1'b0;
    imem_req = 1'b0; dmem_req = 1'b0;

    // Directed table; the first vector is accepted on the first edge after reset release
    for (int v = 0; v < 13; v++) begin
      tick(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dc, tbl[v].dw, tbl[v].da, tbl[v].dwd);
      chk("tbl_iack", imem_req_ack, tbl[v].e_iack);
      exp_sel = 4'hF;
      if (tbl[v].e_dbank >= 0) exp_sel[tbl[v].e_dbank] = 1'b0;
      chk("tbl_csb0", sram_csb0, exp_sel);
      exp_sel = 4'hF;
      if (tbl[v].e_ibank >= 0) exp_sel[tbl[v].e_ibank] = 1'b0;
      chk("tbl_csb1", sram_csb1, exp_sel);
      if (tbl[v].e_wmask != 4'b0000) begin
        chk("tbl_wmask0", sram_wmask0[tbl[v].e_dbank*4 +: 4], tbl[v].e_wmask);
        chk("tbl_din0", sram_din0[tbl[v].e_dbank*32 +: 32], tbl[v].e_din);
      end
      idle();
      chk("tbl_iresp", imem_resp, tbl[v].e_iresp);
      chk("tbl_irdata", imem_rdata, tbl[v].e_irdata);
      chk("tbl_dresp", dmem_resp, tbl[v].e_dresp);
      chk("tbl_drdata", dmem_rdata, tbl[v].e_drdata);
      $display("vec %0d: imem %0b@%h dmem %0b cmd %0b w %0d @%h -> iresp %0d dresp %0d drdata %h",
               v, tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dc, tbl[v].dw, tbl[v].da,
               imem_resp, dmem_resp, dmem_rdata);
    end

    // Preload the random working set through the dmem port
    for (int b = 0; b < NBANK; b++)
      for (int w = 0; w < 8; w++)
        tick(1'b0, 32'h0, 1'b1, 1'b1, 2'd2, b * BANK_BYTES + w * 4, $urandom);

    // Randomized concurrent traffic on both ports
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] da;
      logic [1:0] dw;
      dw = 2'($urandom_range(0, 2));
      if ($urandom % 16 == 0) dw = 2'd3;
      da = rand_addr();
      if ($urandom % 4 != 0) begin
        if (dw == 2'd1) da[0] = 1'b0;
        if (dw == 2'd2) da[1:0] = 2'b00;
      end
      tick($urandom % 4 != 0, rand_addr() & 32'hFFFF_FFFC, $urandom % 4 != 0, $urandom % 2 == 1,
           dw, da, $urandom);
    end
    repeat (3) idle();

    // Reset pulse one cycle after an accepted read: the read must never answer
    tick(1'b1, 32'h104, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    imem_req = 1'b0; dmem_req = 1'b0;
    #1;
    chk("midrst_imem_resp", imem_resp, NOTRDY);
    chk("midrst_dmem_resp", dmem_resp, NOTRDY);
    chk("midrst_csb0", sram_csb0, 4'hF);
    iq.delete(); dq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) idle();

    // Fetch/write collision on the same word: fetch retried next cycle, sees the new data
    tick(1'b1, 32'h10, 1'b1, 1'b1, 2'd2, 32'h10, 32'h5A5AC3C3);
    chk("confl_iack0", imem_req_ack, 1'b0);
    tick(1'b1, 32'h10, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("confl_iack1", imem_req_ack, 1'b1);
    idle();
    chk("confl_iresp", imem_resp, OK);
    chk("confl_irdata", imem_rdata, 32'h5A5AC3C3);

    // Back-to-back dmem write then read of the same word
    tick(1'b0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h1804, 32'hCAFEF00D);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h1804, 32'h0);
    idle();
    chk("wr_rd_rdata", dmem_rdata, 32'hCAFEF00D);

    // Continuous fetches, one per cycle
    tick(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick(1'b1, 32'h4, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick(1'b1, 32'h8, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (4) idle();

    if (iq.size() != 0 || dq.size() != 0) begin
      n_vec++; n_mis++;
      $display("FAIL pending_responses: %0d imem and %0d dmem responses never seen, expected 0",
               iq.size(), dq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
